// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Byte-stream program loader placed in front of Single_Cycle_Top. After
//   reset it accepts a framed image (LEN_LO, LEN_HI, 4*N payload bytes, one
//   XOR checksum byte), writes each assembled 32-bit word into the
//   instruction-memory write port and, once the checksum matches, releases
//   the core from reset. A bad length or checksum parks the loader in an
//   error state with the core still held in reset.
//
// Handshake: a byte transfers on a rising clk edge where in_valid and
//   in_ready are both 1; in_data is ignored at every other edge.
//
// Ports
//   clk          system clock, rising-edge
//   rst          asynchronous active-low reset
//   in_valid     in_data holds a byte
//   in_data      stream byte
//   in_ready     loader accepts a byte this cycle (registered)
//   imem_we      instruction-memory write strobe, one cycle per word
//   imem_addr    word address of the write (held while imem_we=0)
//   imem_wdata   word to write (held while imem_we=0)
//   core_rst     active-low reset for the core; 1 only after a verified load
//   done         image loaded and verified
//   error        image rejected
//   words_loaded number of imem_we pulses since reset
//   state_dbg    current FSM state, for observation only
module imem_boot_loader #(
   parameter int ADDR_WIDTH = 10,
   parameter int MAX_WORDS  = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  core_rst,
   output logic                  done,
   output logic                  error,
   output logic [15:0]           words_loaded,
   output logic [2:0]            state_dbg
);

   // Loading states are encoded 0..3 so "still loading" is simply !state[2].
   localparam logic [2:0] S_LEN_LO  = 3'd0;
   localparam logic [2:0] S_LEN_HI  = 3'd1;
   localparam logic [2:0] S_PAYLOAD = 3'd2;
   localparam logic [2:0] S_CHECK   = 3'd3;
   localparam logic [2:0] S_RUN     = 3'd4;
   localparam logic [2:0] S_ERROR   = 3'd5;

   // 17 bits so a 16-bit length can be compared without truncation.
   localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

   logic [2:0]  state, state_nxt;
   logic [7:0]  len_lo;
   logic [15:0] len;
   logic [15:0] word_idx;
   logic [1:0]  byte_idx;
   logic [7:0]  csum;
   logic [23:0] word_buf;   // lanes 0..2 of the word being assembled

   logic        accept;
   logic [15:0] len_full;
   logic        last_word;

   assign accept    = in_valid & in_ready;
   assign len_full  = {in_data, len_lo};
   assign last_word = (word_idx == len - 16'd1);
   assign state_dbg = state;

   always_comb begin
      state_nxt = state;
      case (state)
         S_LEN_LO:  if (accept) state_nxt = S_LEN_HI;
         S_LEN_HI:
            if (accept) begin
               if ({1'b0, len_full} > MAX_LEN) state_nxt = S_ERROR;
               else if (len_full == 16'd0)     state_nxt = S_CHECK;
               else                            state_nxt = S_PAYLOAD;
            end
         S_PAYLOAD: if (accept && byte_idx == 2'd3 && last_word) state_nxt = S_CHECK;
         S_CHECK:
            if (accept) state_nxt = (in_data == csum) ? S_RUN : S_ERROR;
         S_RUN:     state_nxt = S_RUN;
         S_ERROR:   state_nxt = S_ERROR;
         default:   state_nxt = S_ERROR;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_LEN_LO;
         in_ready     <= 1'b0;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
         core_rst     <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         words_loaded <= '0;
         len_lo       <= '0;
         len          <= '0;
         word_idx     <= '0;
         byte_idx     <= '0;
         csum         <= '0;
         word_buf     <= '0;
      end else begin
         state    <= state_nxt;
         in_ready <= ~state_nxt[2];
         done     <= (state_nxt == S_RUN);
         core_rst <= (state_nxt == S_RUN);
         error    <= (state_nxt == S_ERROR);
         imem_we  <= 1'b0;

         if (accept) begin
            case (state)
               S_LEN_LO: len_lo <= in_data;
               S_LEN_HI: len    <= len_full;
               S_PAYLOAD: begin
                  csum     <= csum ^ in_data;
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: word_buf[7:0]   <= in_data;
                     2'd1: word_buf[15:8]  <= in_data;
                     2'd2: word_buf[23:16] <= in_data;
                     default: begin
                        // Write path has its own registers, so the byte
                        // stream never stalls while a word is written.
                        imem_we      <= 1'b1;
                        imem_addr    <= ADDR_WIDTH'(word_idx);
                        imem_wdata   <= {in_data, word_buf};
                        word_idx     <= word_idx + 16'd1;
                        words_loaded <= words_loaded + 16'd1;
                     end
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: two-word image, bad checksum, empty
// image, oversize length (MAX_WORDS=4 instance), random valid gaps and a
// reset in the middle of a word followed by a replay.
module tb_imem_boot_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready, imem_we, core_rst, done, error;
   logic [9:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic [15:0] words_loaded;
   logic [2:0]  state_dbg;

   logic        s_valid = 1'b0;
   logic [7:0]  s_data = 8'h00;
   logic        s_ready, s_we, s_core_rst, s_done, s_error;
   logic [9:0]  s_addr;
   logic [31:0] s_wdata;
   logic [15:0] s_words;
   logic [2:0]  s_state;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // scoreboard: {addr, data} of each expected write, in order
   logic [41:0] exp_q[$];

   imem_boot_loader #(.ADDR_WIDTH(10), .MAX_WORDS(1024)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .core_rst(core_rst), .done(done),
      .error(error), .words_loaded(words_loaded), .state_dbg(state_dbg)
   );

   imem_boot_loader #(.ADDR_WIDTH(10), .MAX_WORDS(4)) dut_small (
      .clk(clk), .rst(rst), .in_valid(s_valid), .in_data(s_data),
      .in_ready(s_ready), .imem_we(s_we), .imem_addr(s_addr),
      .imem_wdata(s_wdata), .core_rst(s_core_rst), .done(s_done),
      .error(s_error), .words_loaded(s_words), .state_dbg(s_state)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // write monitor / scoreboard
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("we_unexpected", {31'd0, imem_we}, 32'd0);
         end else begin
            logic [41:0] e;
            e = exp_q.pop_front();
            chk("we_addr", {22'd0, imem_addr}, {22'd0, e[41:32]});
            chk("we_data", imem_wdata, e[31:0]);
         end
      end
      if (s_we === 1'b1) chk("small_we", {31'd0, s_we}, 32'd0);
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "_we"},    {31'd0, imem_we}, 32'd0);
      chk({tag, "_addr"},  {22'd0, imem_addr}, 32'd0);
      chk({tag, "_wdata"}, imem_wdata, 32'd0);
      chk({tag, "_crst"},  {31'd0, core_rst}, 32'd0);
      chk({tag, "_done"},  {31'd0, done}, 32'd0);
      chk({tag, "_err"},   {31'd0, error}, 32'd0);
      chk({tag, "_words"}, {16'd0, words_loaded}, 32'd0);
      chk({tag, "_state"}, {29'd0, state_dbg}, 32'd0);
   endtask

   // assert reset, check outputs asynchronously, release, check in_ready rises
   task automatic do_reset(input string tag);
      in_valid = 1'b0; s_valid = 1'b0;
      rst = 1'b0;
      #1;
      check_reset_outputs(tag);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      chk({tag, "_ready_low"}, {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      chk({tag, "_ready_up"}, {31'd0, in_ready}, 32'd1);
      chk({tag, "_s_ready_up"}, {31'd0, s_ready}, 32'd1);
   endtask

   // present one byte, with optional idle cycles first; returns #1 after the accepting edge
   task automatic send_byte(input bit sel, input logic [7:0] b, input bit gaps);
      bit rdy;
      int budget;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0; in_data = 'x;
            @(posedge clk);
            #1;
         end
      end
      if (sel) begin s_valid = 1'b1; s_data = b; end
      else     begin in_valid = 1'b1; in_data = b; end
      rdy = 1'b0;
      budget = 0;
      while (!rdy && budget < 20) begin
         @(negedge clk);
         rdy = sel ? s_ready : in_ready;
         @(posedge clk);
         #1;
         budget++;
      end
      if (!rdy) chk("accept_timeout", {31'd0, rdy}, 32'd1);
      if (sel) s_valid = 1'b0;
      else begin in_valid = 1'b0; in_data = 'x; end
   endtask

   // two-word image 02 00 93 02 50 00 13 03 A0 00 <cks>
   task automatic run_s1(input string tag, input bit gaps, input logic [7:0] cks);
      logic [7:0] s1 [0:9];
      int c0;
      bit ok;
      s1 = '{8'h02, 8'h00, 8'h93, 8'h02, 8'h50, 8'h00, 8'h13, 8'h03, 8'hA0, 8'h00};
      ok = (cks == 8'h71);
      exp_q.push_back({10'd0, 32'h0050_0293});
      exp_q.push_back({10'd1, 32'h00A0_0313});
      c0 = cyc;
      for (int i = 0; i < 10; i++) begin
         send_byte(1'b0, s1[i], gaps);
         if (i == 5 || i == 9) chk({tag, "_we_lat"}, {31'd0, imem_we}, 32'd1);
      end
      send_byte(1'b0, cks, gaps);
      if (!gaps) chk({tag, "_full_rate"}, cyc - c0, 32'd11);
      chk({tag, "_done"},  {31'd0, done}, {31'd0, ok});
      chk({tag, "_crst"},  {31'd0, core_rst}, {31'd0, ok});
      chk({tag, "_err"},   {31'd0, error}, {31'd0, !ok});
      chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "_words"}, {16'd0, words_loaded}, 32'd2);
      chk({tag, "_state"}, {29'd0, state_dbg}, ok ? 32'd4 : 32'd5);
      chk({tag, "_q_empty"}, exp_q.size(), 32'd0);
      // terminal state: later bytes are ignored
      in_valid = 1'b1;
      repeat (4) begin
         in_data = 8'($urandom);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk({tag, "_hold_state"}, {29'd0, state_dbg}, ok ? 32'd4 : 32'd5);
      chk({tag, "_hold_words"}, {16'd0, words_loaded}, 32'd2);
      chk({tag, "_hold_done"},  {31'd0, done}, {31'd0, ok});
      chk({tag, "_hold_err"},   {31'd0, error}, {31'd0, !ok});
   endtask

   initial begin
      #3;
      do_reset("rst0");

      // scenario 1: good two-word image, full rate
      run_s1("s1", 1'b0, 8'h71);

      // scenario 2: bad checksum
      do_reset("rst1");
      run_s1("s2", 1'b0, 8'h70);

      // scenario 3: empty image
      do_reset("rst2");
      send_byte(1'b0, 8'h00, 1'b0);
      send_byte(1'b0, 8'h00, 1'b0);
      chk("s3_state_check", {29'd0, state_dbg}, 32'd3);
      chk("s3_not_done_yet", {31'd0, done}, 32'd0);
      send_byte(1'b0, 8'h00, 1'b0);
      chk("s3_done",  {31'd0, done}, 32'd1);
      chk("s3_crst",  {31'd0, core_rst}, 32'd1);
      chk("s3_ready", {31'd0, in_ready}, 32'd0);
      chk("s3_words", {16'd0, words_loaded}, 32'd0);

      // scenario 4: length 5 on the MAX_WORDS=4 instance
      send_byte(1'b1, 8'h05, 1'b0);
      chk("s4_no_err_yet", {31'd0, s_error}, 32'd0);
      send_byte(1'b1, 8'h00, 1'b0);
      chk("s4_err",   {31'd0, s_error}, 32'd1);
      chk("s4_done",  {31'd0, s_done}, 32'd0);
      chk("s4_crst",  {31'd0, s_core_rst}, 32'd0);
      chk("s4_ready", {31'd0, s_ready}, 32'd0);
      chk("s4_words", {16'd0, s_words}, 32'd0);

      // scenario 5: scenario 1 with random valid gaps
      do_reset("rst3");
      run_s1("s5", 1'b1, 8'h71);

      // scenario 6: reset after 5 payload bytes, then replay
      do_reset("rst4");
      exp_q.push_back({10'd0, 32'h0050_0293});
      send_byte(1'b0, 8'h02, 1'b0);
      send_byte(1'b0, 8'h00, 1'b0);
      send_byte(1'b0, 8'h93, 1'b0);
      send_byte(1'b0, 8'h02, 1'b0);
      send_byte(1'b0, 8'h50, 1'b0);
      send_byte(1'b0, 8'h00, 1'b0);
      chk("s6_we_word0", {31'd0, imem_we}, 32'd1);
      send_byte(1'b0, 8'h13, 1'b0);
      chk("s6_words_mid", {16'd0, words_loaded}, 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("s6_async");
      chk("s6_q_empty", exp_q.size(), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("s6_ready_up", {31'd0, in_ready}, 32'd1);
      run_s1("s6r", 1'b0, 8'h71);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Byte-stream program loader that sits directly upstream of Single_Cycle_Top. After reset it accepts a framed program image over a valid/ready byte interface and writes it, word by word, into the instruction-memory write port. It verifies a checksum, then releases the core's reset. The core stays in reset until a complete, valid image has been loaded.

Parameters:
ADDR_WIDTH, 10, width of the instruction-memory word address.
MAX_WORDS, 1024, largest accepted image length in 32-bit words; must be <= 2**ADDR_WIDTH.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst  input  1  reset, asynchronous, active-low.
in_valid  input  1  in_data holds a byte.
in_data  input  8  stream byte.
in_ready  output  1  loader can accept a byte this cycle.
imem_we  output  1  instruction-memory write strobe, one cycle per word.
imem_addr  output  ADDR_WIDTH  word address of the write.
imem_wdata  output  32  word to write.
core_rst  output  1  active-low reset driven into Single_Cycle_Top rst.
done  output  1  image loaded and verified; core running.
error  output  1  image rejected; core held in reset.
words_loaded  output  16  count of imem_we pulses issued since reset.

Behaviour:
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N payload bytes (each word little-endian), then 1 checksum byte. The checksum is the XOR of all payload bytes only; the length bytes are excluded.
- Byte accepted only on a rising edge with in_valid=1 and in_ready=1. in_data is ignored otherwise, including X values.
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=0, done=0, error=0, words_loaded=0. State=S_LEN_LO. Internal byte index, word index and checksum accumulator = 0.
- in_ready is registered and equals 1 in S_LEN_LO, S_LEN_HI, S_PAYLOAD and S_CHECK. It first rises on the first clock edge after rst deasserts.
- State transitions:
  - S_LEN_LO -> S_LEN_HI on accept.
  - S_LEN_HI on accept, with N = {byte, LEN_LO}:
    - N > MAX_WORDS -> S_ERROR.
    - N = 0 -> S_CHECK.
    - otherwise -> S_PAYLOAD.
  - S_PAYLOAD: each accepted byte fills lane byte_idx (bits 8*idx+7:8*idx) and is XORed into the checksum. On the 4th byte of a word:
    - On the next edge: imem_we=1 for exactly one cycle, imem_addr = word index, imem_wdata = assembled word, words_loaded increments. Latency: strobe one cycle after the last byte.
    - The write path is separately registered, so in_ready stays 1 and back-to-back bytes are accepted at full rate.
    - After word N-1 the state -> S_CHECK.
  - S_CHECK on accept:
    - byte == accumulator -> S_RUN.
    - otherwise -> S_ERROR.
  - S_RUN (terminal): in_ready=0, done=1, core_rst=1. All three update on the edge that enters S_RUN.
  - S_ERROR (terminal): in_ready=0, error=1, core_rst=0.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- done and error are never both 1.
- Terminal states are left only by rst.
- rst asserted at any time, including mid-word or mid-write-pulse:
  - All outputs return to their reset values immediately (asynchronously).
  - Instruction memory is not cleared; a partial word is never written.
  - After rst deasserts, loading restarts at S_LEN_LO.
- Address wrap cannot occur, because N <= MAX_WORDS <= 2**ADDR_WIDTH.

Test Plan:
- Two-word image: stream 02 00 93 02 50 00 13 03 A0 00 71, in_valid held high.
  - Required: imem_we pulses with addr0=0x00500293, then addr1=0x00A00313.
  - Each pulse comes one cycle after the word's 4th byte.
  - On the edge accepting 0x71: done=1, core_rst=1, in_ready=0; words_loaded=2.
- Same stream with checksum 0x70 -> error=1, done=0, core_rst=0, words_loaded=2, in_ready=0; further valid bytes are ignored.
- Empty image: 00 00 00 -> no imem_we; done=1, core_rst=1 on the third accept.
- MAX_WORDS=4, stream 05 00 -> error=1 on the LEN_HI accept; no writes.
- Scenario 1 with in_valid deasserted on random cycles (in_data=X while low) -> identical writes, checksum result and final state.
- Assert rst after 5 payload-phase bytes (mid word 1):
  - All outputs return to reset values; no imem_we to addr1.
  - Deassert rst and replay scenario 1 -> same results as scenario 1.
